con_eval_unit: RTL
==================

# con_eval_unit

Parametrised successor to the branch-condition logic of the datapath. It evaluates a branch condition against values taken from the internal bus and holds the result in a registered CON flag for the control unit. It extends the single-operand zero/sign tests with two-operand compares, which capture operand A and operand B on two consecutive bus strobes. It sits between `BusMuxOut` and the control unit's branch decision input.

## Interface
Parameters:
- `WIDTH`, 32, bus and operand width (≥2)
- `STAT_W`, 16, statistics counter width (used only with `CON_STATS_EN`)

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `clear_n`  in  1  synchronous, active-low reset
- `con_in`  in  1  strobe: sample `bus_mux_out` this cycle
- `con_abort`  in  1  cancel a pending two-operand compare
- `cond`  in  3  condition code, sampled with the first strobe of an evaluation
- `bus_mux_out`  in  WIDTH  bus value
- `con_out`  out  1  registered CON flag
- `con_valid`  out  1  one-cycle pulse: `con_out` was just updated
- `con_busy`  out  1  high while waiting for operand B
- `taken_cnt`  out  STAT_W  evaluations with result 1 (only with `CON_STATS_EN`)
- `eval_cnt`  out  STAT_W  total completed evaluations (only with `CON_STATS_EN`)

## Operation
Condition codes:
- 0: A==0
- 1: A!=0
- 2: A[MSB]==0
- 3: A[MSB]==1
- 4: A==B
- 5: A!=B
- 6: A<B signed
- 7: A<B unsigned

Codes 0–3 are single-operand; codes 4–7 are two-operand.

States:
- IDLE
  - `con_in` with `cond`<4: evaluate on A=`bus_mux_out`, update `con_out`, pulse `con_valid`, stay in IDLE.
  - `con_in` with `cond`≥4: latch A and `cond` into internal registers, go to WAIT_B.
- WAIT_B
  - `con_in`: B=`bus_mux_out`, evaluate with the latched `cond` and A, update `con_out`, pulse `con_valid`, go to IDLE. The live `cond` input is ignored.
  - `con_abort` without `con_in`: go to IDLE; `con_out` unchanged; no `con_valid`.
  - `con_abort` and `con_in` in the same cycle: abort wins; B is discarded.
  - `con_abort` in IDLE: no effect.

Behaviour common to all states:
- `con_out` holds its value between evaluations.
- `con_busy` = (state==WAIT_B).
- Arithmetic:
  - Compares use the full WIDTH.
  - Signed compare treats bit WIDTH-1 as the sign bit.
  - No truncation or extension occurs.
- Reset (`clear_n`=0 at an edge), from any state including WAIT_B:
  - state to IDLE, `con_out`=0, `con_valid`=0, `con_busy`=0, latched A/`cond`=0, counters=0.
  - Reset overrides `con_in` and `con_abort` in the same cycle.

## Timing
- Single-operand latency is 1 cycle: strobe sampled at edge N; `con_out`/`con_valid` visible after edge N.
- Two-operand latency is 1 cycle after the B strobe.
- The minimum A→B spacing is 1 cycle, so back-to-back strobes are legal.
- The WAIT_B dwell time is unbounded.
- `con_valid` is high for exactly one cycle per completed evaluation.
- Back-to-back single-operand strobes produce a `con_valid` on every cycle.
- No combinational path from inputs to outputs.

## Configuration
Macro `CON_STATS_EN`:
- Defined:
  - `eval_cnt` increments on every `con_valid`.
  - `taken_cnt` increments on every `con_valid` whose result is 1.
  - Both counters saturate at 2^STAT_W−1.
  - Both counters reset to 0.
- Undefined: counters and their ports are absent; no other behaviour change.

## Structure
Shared package holds:
- the condition-code constants (`CC_ZERO`, `CC_NZ`, `CC_POS`, `CC_NEG`, `CC_EQ`, `CC_NE`, `CC_LT`, `CC_LTU`)
- the state encoding (`ST_IDLE`, `ST_WAIT_B`)

The comparator is a natural combinational sub-module, `con_compare`:
- inputs: `cond`, A, B
- output: the 1-bit result
- `con_eval_unit` wraps it with the FSM, operand/cond latches, output register and optional counters.

## Test plan
- Reset then idle: `clear_n`=0 for 2 cycles → `con_out`=0, `con_valid`=0, `con_busy`=0, counters 0.
- Single-operand codes: `cond`=0 with bus 0x0 → `con_out`=1, `con_valid` pulse next cycle. `cond`=3 with 0x80000000 → 1. `cond`=2 with 0x80000000 → 0.
- Two-operand signed vs unsigned:
  - A=0xFFFFFFFF, B=0x00000001, `cond`=6 → `con_busy`=1 after the A strobe, then `con_out`=1.
  - Same A and B with `cond`=7 → `con_out`=0.
- Latched cond: A strobe with `cond`=4 (A=5), then B strobe with `cond`=0 on the pins and B=5 → `con_out`=1; the live `cond` is ignored.
- Abort precedence: in WAIT_B with a prior `con_out`=1, assert `con_abort` and `con_in` together → IDLE, no `con_valid`, `con_out` stays 1, `con_busy`=0.
- Reset mid-compare: in WAIT_B assert `clear_n`=0 with `con_in` → `con_out`=0, IDLE. With `CON_STATS_EN`, after 3 evaluations (results 1,0,1): `eval_cnt`=3, `taken_cnt`=2. With `STAT_W`=2, a 5th evaluation leaves `eval_cnt`=3 (saturated).

Source files
------------

// File: rtl/con_eval_unit_pkg.sv
// Shared definitions for the branch-condition evaluator: condition codes and
// the FSM state encoding.
package con_eval_unit_pkg;

  localparam logic [2:0] CC_ZERO = 3'd0;
  localparam logic [2:0] CC_NZ   = 3'd1;
  localparam logic [2:0] CC_POS  = 3'd2;
  localparam logic [2:0] CC_NEG  = 3'd3;
  localparam logic [2:0] CC_EQ   = 3'd4;
  localparam logic [2:0] CC_NE   = 3'd5;
  localparam logic [2:0] CC_LT   = 3'd6;
  localparam logic [2:0] CC_LTU  = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WAIT_B = 1'b1
  } con_state_t;

endpackage

// File: rtl/con_compare.sv
// Combinational condition evaluator. Codes 0-3 look only at a; codes 4-7
// compare a against b over the full width.
module con_compare
  import con_eval_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result
);

  always_comb begin
    result = 1'b0;
    case (cond)
      CC_ZERO: result = (a == '0);
      CC_NZ:   result = (a != '0);
      CC_POS:  result = ~a[WIDTH-1];
      CC_NEG:  result = a[WIDTH-1];
      CC_EQ:   result = (a == b);
      CC_NE:   result = (a != b);
      CC_LT:   result = ($signed(a) < $signed(b));
      CC_LTU:  result = (a < b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/con_eval_unit.sv
// Registered branch-condition flag with single- and two-operand evaluation.
// Optional statistics counters are built when CON_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | ready; single-operand codes evaluate here, two-operand codes latch A
// ST_WAIT_B | A and cond latched; next strobe supplies B unless aborted
module con_eval_unit
  import con_eval_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              con_in,
  input  logic              con_abort,
  input  logic [2:0]        cond,
  input  logic [WIDTH-1:0]  bus_mux_out,
  output logic              con_out,
  output logic              con_valid,
  output logic              con_busy
`ifdef CON_STATS_EN
  ,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] eval_cnt
`endif
);

  if (WIDTH < 2 || STAT_W < 1) begin : g_param_check
    $error("con_eval_unit: WIDTH must be >= 2 and STAT_W >= 1");
  end

  con_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [2:0]       cond_q;
  logic             do_eval;
  logic             do_latch;
  logic [2:0]       cmp_cond;
  logic [WIDTH-1:0] cmp_a;
  logic             cmp_res;

  // In WAIT_B the comparator sees the latched A/cond and the live bus as B.
  always_comb begin
    cmp_cond = cond;
    cmp_a    = bus_mux_out;
    if (state == ST_WAIT_B) begin
      cmp_cond = cond_q;
      cmp_a    = a_q;
    end
  end

  con_compare #(.WIDTH(WIDTH)) u_compare (
    .cond   (cmp_cond),
    .a      (cmp_a),
    .b      (bus_mux_out),
    .result (cmp_res)
  );

  always_comb begin
    state_nxt = state;
    do_eval   = 1'b0;
    do_latch  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (con_in) begin
          if (cond[2]) begin
            do_latch  = 1'b1;
            state_nxt = ST_WAIT_B;
          end else begin
            do_eval = 1'b1;
          end
        end
      end
      ST_WAIT_B: begin
        // Abort takes priority over a coincident B strobe.
        if (con_abort) begin
          state_nxt = ST_IDLE;
        end else if (con_in) begin
          do_eval   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      cond_q    <= '0;
      con_out   <= 1'b0;
      con_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      con_valid <= do_eval;
      if (do_latch) begin
        a_q    <= bus_mux_out;
        cond_q <= cond;
      end
      if (do_eval) begin
        con_out <= cmp_res;
      end
    end
  end

  assign con_busy = (state == ST_WAIT_B);

`ifdef CON_STATS_EN
  localparam logic [STAT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (do_eval) begin
      if (eval_cnt != CNT_MAX) begin
        eval_cnt <= eval_cnt + 1'b1;
      end
      if (cmp_res && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
